// File: rtl/mem_port2_arbiter.sv
// Two-requester (CPU / external loader) arbiter for port 2 of a 16x1k memory.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is CPU priority with an ext starvation guard.
module mem_port2_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [15:0] ext_addr,
    input  logic [15:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [15:0] rdata,
    output logic        mem_r2,
    output logic        mem_w2,
    output logic [15:0] mem_a2,
    output logic [15:0] mem_write2,
    input  logic [15:0] mem_readout2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]  r_state;
    logic        r_we;
    logic        r_owner_ext;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic w_arb;
    logic w_contend;
    logic w_ext_priority;
    logic w_pick_ext;
    logic w_issue;
    logic w_resp_rd;

    // Arbitration happens at any edge that is not ending an ISSUE cycle.
    assign w_contend  = cpu_req & ext_req;
    assign w_arb      = ((r_state == S_IDLE) || (r_state == S_RESP)) && (cpu_req || ext_req);
    assign w_pick_ext = w_contend ? w_ext_priority : ext_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_ext_next;

    assign w_ext_priority = r_rr_ext_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ext_next <= 1'b0;
        end else if (w_arb) begin
            r_rr_ext_next <= !w_pick_ext;
        end
    end
`else
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;

    assign w_ext_priority = (r_starve_cnt == LIMIT);

    // Counts CPU wins while ext waits; once at LIMIT ext wins the next contention, so it never overflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_arb) begin
            if (!w_pick_ext && ext_req) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_owner_ext <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_arb) begin
                        r_state     <= S_ISSUE;
                        r_owner_ext <= w_pick_ext;
                        r_we        <= w_pick_ext ? ext_we    : cpu_we;
                        r_addr      <= w_pick_ext ? ext_addr  : cpu_addr;
                        r_wdata     <= w_pick_ext ? ext_wdata : cpu_wdata;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pulses are masked while reset is high so an aborted access shows nothing further.
    assign w_issue   = (r_state == S_ISSUE) && !reset;
    assign w_resp_rd = (r_state == S_RESP) && !r_we && !reset;

    assign cpu_gnt    = w_issue & !r_owner_ext;
    assign ext_gnt    = w_issue &  r_owner_ext;
    assign mem_r2     = w_issue & !r_we;
    assign mem_w2     = w_issue &  r_we;
    assign cpu_rvalid = w_resp_rd & !r_owner_ext;
    assign ext_rvalid = w_resp_rd &  r_owner_ext;
    assign rdata      = w_resp_rd ? mem_readout2 : 16'h0000;
    assign mem_a2     = r_addr;
    assign mem_write2 = r_wdata;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Self-checking bench for mem_port2_arbiter: directed vector table, corner sequences, random vs. reference model.
module tb_mem_port2_arbiter;

    localparam int STARVE = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
    logic [15:0] rdata;
    logic        mem_r2, mem_w2;
    logic [15:0] mem_a2, mem_write2, mem_readout2;

    int total = 0;
    int bad   = 0;

    mem_port2_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .rdata(rdata), .mem_r2(mem_r2), .mem_w2(mem_w2),
        .mem_a2(mem_a2), .mem_write2(mem_write2), .mem_readout2(mem_readout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 1-cycle registered read; bench preload port takes precedence.
    logic [15:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_w2) mem[mem_a2[9:0]] <= mem_write2;
        if (mem_r2) mem_readout2 <= mem[mem_a2[9:0]];
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        pre_we = 1; pre_addr = a; pre_data = d;
        step();
        pre_we = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    typedef struct {
        logic        cr, cw; logic [15:0] ca, cd;
        logic        er, ew; logic [15:0] ea, ed;
        logic        cg, eg, r2, w2; logic [15:0] a2, wd;
        logic        crv, erv; logic [15:0] rd;
    } vec_t;

    vec_t tbl [9];

    // Random-phase reference model state
    logic [15:0] ref_mem [0:63];
    logic        granted_prev, granted_now, pend_rv, pend_ext, win_ext, w_we;
    logic [15:0] pend_data, m_a2, m_wd, w_addr, w_wd;
    logic        rr_ext_next;
    int          cpu_streak;
    logic        e_cg, e_eg, e_r2, e_w2, e_crv, e_erv;
    logic [15:0] e_rd;
    logic        exp_ext;

    initial begin
        idle_inputs();
        pre_we = 0; pre_addr = 0; pre_data = 0;
        reset = 1;
        preload(10'h010, 16'hBEEF);
        preload(10'h020, 16'h5555);
        step();
        chk1("rst_cpu_gnt", cpu_gnt, 0);   chk1("rst_ext_gnt", ext_gnt, 0);
        chk1("rst_mem_r2", mem_r2, 0);     chk1("rst_mem_w2", mem_w2, 0);
        chk1("rst_cpu_rvalid", cpu_rvalid, 0); chk1("rst_ext_rvalid", ext_rvalid, 0);
        chk16("rst_mem_a2", mem_a2, 0);    chk16("rst_mem_write2", mem_write2, 0);
        chk16("rst_rdata", rdata, 0);
        reset = 0;
        step();

        // Directed table: CPU read (addr change during ISSUE), ext write, CPU read-back.
        tbl[0] = '{1,0,16'h0010,16'h0, 0,0,16'h0,16'h0,    1,0,1,0,16'h0010,16'h0000, 0,0,16'h0000};
        tbl[1] = '{1,0,16'h0020,16'h0, 0,0,16'h0,16'h0,    0,0,0,0,16'h0010,16'h0000, 1,0,16'hBEEF};
        tbl[2] = '{1,0,16'h0020,16'h0, 0,0,16'h0,16'h0,    1,0,1,0,16'h0020,16'h0000, 0,0,16'h0000};
        tbl[3] = '{0,0,16'h0000,16'h0, 0,0,16'h0,16'h0,    0,0,0,0,16'h0020,16'h0000, 1,0,16'h5555};
        tbl[4] = '{0,0,16'h0000,16'h0, 1,1,16'h0200,16'h1234, 0,1,0,1,16'h0200,16'h1234, 0,0,16'h0000};
        tbl[5] = '{1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,0,0,0,16'h0200,16'h1234, 0,0,16'h0000};
        tbl[6] = '{1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    1,0,1,0,16'h0200,16'h0000, 0,0,16'h0000};
        tbl[7] = '{0,0,16'h0000,16'h0, 0,0,16'h0,16'h0,    0,0,0,0,16'h0200,16'h0000, 1,0,16'h1234};
        tbl[8] = '{0,0,16'h0000,16'h0, 0,0,16'h0,16'h0,    0,0,0,0,16'h0200,16'h0000, 0,0,16'h0000};
        for (int i = 0; i < 9; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            ext_req = tbl[i].er; ext_we = tbl[i].ew; ext_addr = tbl[i].ea; ext_wdata = tbl[i].ed;
            step();
            chk1("tbl_cpu_gnt", cpu_gnt, tbl[i].cg);
            chk1("tbl_ext_gnt", ext_gnt, tbl[i].eg);
            chk1("tbl_mem_r2", mem_r2, tbl[i].r2);
            chk1("tbl_mem_w2", mem_w2, tbl[i].w2);
            chk16("tbl_mem_a2", mem_a2, tbl[i].a2);
            chk16("tbl_mem_write2", mem_write2, tbl[i].wd);
            chk1("tbl_cpu_rvalid", cpu_rvalid, tbl[i].crv);
            chk1("tbl_ext_rvalid", ext_rvalid, tbl[i].erv);
            if (tbl[i].crv || tbl[i].erv) chk16("tbl_rdata", rdata, tbl[i].rd);
            $display("vec %0d: gnt c/e=%b%b r2/w2=%b%b a2=%h rv c/e=%b%b rdata=%h",
                     i, cpu_gnt, ext_gnt, mem_r2, mem_w2, mem_a2, cpu_rvalid, ext_rvalid, rdata);
        end

        // Reset raised during RESP of a CPU read aborts it.
        cpu_req = 1; cpu_addr = 16'h0010;
        step();
        chk1("abort_issue_gnt", cpu_gnt, 1);
        cpu_req = 0;
        step();
        reset = 1;
        #1;
        chk1("abort_no_rvalid", cpu_rvalid, 0);
        step();
        reset = 0;
        chk1("abort_cpu_gnt", cpu_gnt, 0);     chk1("abort_mem_r2", mem_r2, 0);
        chk1("abort_cpu_rvalid", cpu_rvalid, 0);
        chk16("abort_mem_a2", mem_a2, 0);      chk16("abort_rdata", rdata, 0);
        cpu_req = 1; cpu_addr = 16'h0020;
        step();
        chk1("post_rst_gnt", cpu_gnt, 1);
        chk16("post_rst_a2", mem_a2, 16'h0020);
        cpu_req = 0;
        step();
        chk1("post_rst_rvalid", cpu_rvalid, 1);
        chk16("post_rst_rdata", rdata, 16'h5555);
        $display("abort seq: post-reset read rdata=%h", rdata);
        step();

        // Sustained contention for 16 cycles from a fresh reset.
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0020;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k % 2 == 1) begin
                exp_ext = RR ? (((k - 1) / 2) % 2 == 1) : (((k - 1) / 2) % (STARVE + 1) == STARVE);
                chk1("cont_cpu_gnt", cpu_gnt, !exp_ext);
                chk1("cont_ext_gnt", ext_gnt, exp_ext);
                chk16("cont_mem_a2", mem_a2, exp_ext ? 16'h0020 : 16'h0010);
                $display("contention cycle %0d: cpu_gnt=%b ext_gnt=%b", k, cpu_gnt, ext_gnt);
            end else begin
                chk1("cont_gap_gnt", cpu_gnt | ext_gnt, 0);
            end
        end
        idle_inputs();
        step();
        step();

        // Randomized traffic against a rule-level model.
        reset = 1;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'(i * 16'h0307) ^ 16'hA5C3;
            preload(10'(i), ref_mem[i]);
        end
        reset = 0;
        granted_prev = 0; pend_rv = 0; pend_ext = 0; pend_data = 0;
        m_a2 = 0; m_wd = 0; rr_ext_next = 0; cpu_streak = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            e_cg = 0; e_eg = 0; e_r2 = 0; e_w2 = 0; e_crv = 0; e_erv = 0; e_rd = 0;
            if (pend_rv) begin
                e_crv = !pend_ext; e_erv = pend_ext; e_rd = pend_data;
            end
            pend_rv = 0;
            granted_now = 0;
            // A new access may start at any edge not directly following a grant.
            if (!granted_prev && (cpu_req || ext_req)) begin
                if (cpu_req && ext_req) win_ext = RR ? rr_ext_next : (cpu_streak == STARVE);
                else win_ext = ext_req;
                rr_ext_next = !win_ext;
                cpu_streak = (!win_ext && ext_req) ? cpu_streak + 1 : 0;
                w_we = win_ext ? ext_we : cpu_we;
                w_addr = win_ext ? ext_addr : cpu_addr;
                w_wd = win_ext ? ext_wdata : cpu_wdata;
                e_cg = !win_ext; e_eg = win_ext; e_r2 = !w_we; e_w2 = w_we;
                m_a2 = w_addr; m_wd = w_wd;
                if (w_we) ref_mem[w_addr[5:0]] = w_wd;
                else begin
                    pend_rv = 1; pend_ext = win_ext; pend_data = ref_mem[w_addr[5:0]];
                end
                granted_now = 1;
            end
            granted_prev = granted_now;
            #1;
            chk1("rnd_cpu_gnt", cpu_gnt, e_cg);
            chk1("rnd_ext_gnt", ext_gnt, e_eg);
            chk1("rnd_mem_r2", mem_r2, e_r2);
            chk1("rnd_mem_w2", mem_w2, e_w2);
            chk16("rnd_mem_a2", mem_a2, m_a2);
            chk16("rnd_mem_write2", mem_write2, m_wd);
            chk1("rnd_cpu_rvalid", cpu_rvalid, e_crv);
            chk1("rnd_ext_rvalid", ext_rvalid, e_erv);
            if (e_crv || e_erv) begin
                chk16("rnd_rdata", rdata, e_rd);
                $display("rnd %0d: %s read rdata=%h", cyc, e_erv ? "ext" : "cpu", rdata);
            end
            if (e_cg || e_eg) $display("rnd %0d: %s %s a2=%h", cyc, e_eg ? "ext" : "cpu", e_w2 ? "write" : "read", mem_a2);
            if (!cpu_req || e_cg) begin
                cpu_req = ($urandom_range(0, 2) != 0);
                cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'($urandom_range(0, 63));
                cpu_wdata = 16'($urandom);
            end
            if (!ext_req || e_eg) begin
                ext_req = ($urandom_range(0, 2) != 0);
                ext_we = 1'($urandom_range(0, 1)); ext_addr = 16'($urandom_range(0, 63));
                ext_wdata = 16'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
